// File: rtl/prog_nonoverlap_clkgen.sv
// prog_nonoverlap_clkgen: single-domain counter-based generator for non-overlapping MOD/MODN and phase-shifted CLKL.
// Config is shadowed and swapped in only at a period boundary so a retune never produces a runt pulse.
module prog_nonoverlap_clkgen #(
    parameter int DIV_W    = 16,
    parameter int DEAD_W   = 8,
    parameter int N_L      = 2,
    parameter int DEF_HALF = 50,
    parameter int DEF_DEAD = 4
) (
    input  logic                     USER_CLOCK,
    input  logic                     RESET_N,
    input  logic                     ENABLE,
    input  logic                     CFG_LOAD,
    input  logic [DIV_W-1:0]         CFG_HALF,
    input  logic [DEAD_W-1:0]        CFG_DEAD,
    input  logic [N_L*(DIV_W+1)-1:0] CFG_PHASE,
    output logic                     CLK_MOD,
    output logic                     CLK_MODN,
    output logic [N_L-1:0]           CLKL_MOD,
    output logic                     PERIOD_STB,
    output logic                     CFG_PENDING,
    output logic                     RUNNING
);
    localparam int CW = DIV_W + 1;
    localparam int XW = (DEAD_W > DIV_W) ? DEAD_W : DIV_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [DIV_W-1:0]  half_q;
    logic [DIV_W-1:0]  dead_q;
    logic [N_L*CW-1:0] phase_q;
    logic [DIV_W-1:0]  half_pnd_q;
    logic [DEAD_W-1:0] dead_pnd_q;
    logic [N_L*CW-1:0] phase_pnd_q;
    logic              pnd_q;
    logic              mod_q;
    logic              modn_q;
    logic              stb_q;
    logic [N_L-1:0]    clkl_q;

    function automatic logic [DIV_W-1:0] sat_half(input logic [DIV_W-1:0] h);
        return (h < DIV_W'(2)) ? DIV_W'(2) : h;
    endfunction

    function automatic logic [DIV_W-1:0] sat_dead(input logic [DEAD_W-1:0] d,
                                                  input logic [DIV_W-1:0]  h);
        return (XW'(d) >= XW'(h)) ? (h - DIV_W'(1)) : DIV_W'(d);
    endfunction

    function automatic logic [CW-1:0] sat_phase(input logic [CW-1:0]    p,
                                                input logic [DIV_W-1:0] h);
        logic [CW-1:0] two_h;
        two_h = {h, 1'b0};
        return (p >= two_h) ? (two_h - CW'(1)) : p;
    endfunction

    // Phase-shifted position wrapped into [0, 2H); never exceeds CW bits since cnt < phase in the wrap branch.
    function automatic logic clkl_level(input logic [CW-1:0]    cnt,
                                        input logic [CW-1:0]    ph,
                                        input logic [DIV_W-1:0] h);
        logic [CW-1:0] s;
        s = (cnt >= ph) ? (cnt - ph) : (cnt + ({h, 1'b0} - ph));
        return s < CW'(h);
    endfunction

    logic [DIV_W-1:0]  app_half;
    logic [DIV_W-1:0]  app_dead;
    logic [N_L*CW-1:0] app_phase;

    always_comb begin
        app_half  = sat_half(half_pnd_q);
        app_dead  = sat_dead(dead_pnd_q, app_half);
        app_phase = '0;
        for (int k = 0; k < N_L; k++) begin
            app_phase[k*CW +: CW] = sat_phase(phase_pnd_q[k*CW +: CW], app_half);
        end
    end

    logic [CW-1:0]  two_h;
    logic           wrap;
    logic           apply;
    logic           dec_mod;
    logic           dec_modn;
    logic [N_L-1:0] dec_clkl;

    // Decode stage: pure function of cnt and active config, registered below for a 1-cycle cnt -> pin latency.
    always_comb begin
        two_h    = {half_q, 1'b0};
        wrap     = (state_q != IDLE) && (cnt_q == two_h - CW'(1));
        apply    = pnd_q && ((state_q == IDLE) ? ENABLE : wrap);
        dec_mod  = (cnt_q >= CW'(dead_q)) && (cnt_q < CW'(half_q));
        dec_modn = (cnt_q >= CW'(half_q) + CW'(dead_q)) && (cnt_q < two_h);
        dec_clkl = '0;
        for (int k = 0; k < N_L; k++) begin
            dec_clkl[k] = clkl_level(cnt_q, phase_q[k*CW +: CW], half_q);
        end
    end

    always_ff @(posedge USER_CLOCK) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            half_q      <= DIV_W'(DEF_HALF);
            dead_q      <= DIV_W'(DEF_DEAD);
            phase_q     <= '0;
            half_pnd_q  <= DIV_W'(DEF_HALF);
            dead_pnd_q  <= DEAD_W'(DEF_DEAD);
            phase_pnd_q <= '0;
            pnd_q       <= 1'b0;
            mod_q       <= 1'b0;
            modn_q      <= 1'b0;
            stb_q       <= 1'b0;
            clkl_q      <= '0;
        end else begin
            if (apply) begin
                half_q  <= app_half;
                dead_q  <= app_dead;
                phase_q <= app_phase;
            end
            // A load coinciding with an apply becomes the next pending value.
            if (CFG_LOAD) begin
                half_pnd_q  <= CFG_HALF;
                dead_pnd_q  <= CFG_DEAD;
                phase_pnd_q <= CFG_PHASE;
            end
            pnd_q <= CFG_LOAD | (pnd_q & ~apply);

            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    mod_q  <= 1'b0;
                    modn_q <= 1'b0;
                    stb_q  <= 1'b0;
                    clkl_q <= '0;
                    if (ENABLE) begin
                        state_q <= RUN;
                    end
                end
                RUN, STOP: begin
                    mod_q  <= dec_mod;
                    modn_q <= dec_modn;
                    stb_q  <= (cnt_q == '0);
                    clkl_q <= (state_q == STOP) ? (clkl_q & dec_clkl) : dec_clkl;
                    cnt_q  <= wrap ? '0 : (cnt_q + CW'(1));
                    if (ENABLE) begin
                        state_q <= RUN;
                    end else if (wrap) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= STOP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign CLK_MOD     = mod_q;
    assign CLK_MODN    = modn_q;
    assign CLKL_MOD    = clkl_q;
    assign PERIOD_STB  = stb_q;
    assign CFG_PENDING = pnd_q;
    assign RUNNING     = (state_q != IDLE);

endmodule

// File: tb/tb_prog_nonoverlap_clkgen.sv
// Bench for prog_nonoverlap_clkgen: period-frame reference model checked every cycle, plus directed literal checks.
module tb_prog_nonoverlap_clkgen;
    localparam int DIV_W    = 16;
    localparam int DEAD_W   = 8;
    localparam int N_L      = 2;
    localparam int CW       = DIV_W + 1;
    localparam int DEF_HALF = 50;
    localparam int DEF_DEAD = 4;

    logic              clk = 1'b0;
    logic              RESET_N = 1'b0;
    logic              ENABLE = 1'b0;
    logic              CFG_LOAD = 1'b0;
    logic [DIV_W-1:0]  CFG_HALF = '0;
    logic [DEAD_W-1:0] CFG_DEAD = '0;
    logic [N_L*CW-1:0] CFG_PHASE = '0;
    logic              CLK_MOD, CLK_MODN, PERIOD_STB, CFG_PENDING, RUNNING;
    logic [N_L-1:0]    CLKL_MOD;

    prog_nonoverlap_clkgen #(
        .DIV_W(DIV_W), .DEAD_W(DEAD_W), .N_L(N_L), .DEF_HALF(DEF_HALF), .DEF_DEAD(DEF_DEAD)
    ) dut (
        .USER_CLOCK(clk), .RESET_N(RESET_N), .ENABLE(ENABLE), .CFG_LOAD(CFG_LOAD),
        .CFG_HALF(CFG_HALF), .CFG_DEAD(CFG_DEAD), .CFG_PHASE(CFG_PHASE),
        .CLK_MOD(CLK_MOD), .CLK_MODN(CLK_MODN), .CLKL_MOD(CLKL_MOD),
        .PERIOD_STB(PERIOD_STB), .CFG_PENDING(CFG_PENDING), .RUNNING(RUNNING)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int prints = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    // Reference model: whole periods are generated as frame lists from the sanitised config.
    typedef struct packed {
        logic           mod;
        logic           modn;
        logic           stb;
        logic [N_L-1:0] clkl;
    } frame_t;

    frame_t fq[$];
    int     m_mode;            // 0 idle, 1 run, 2 stopping
    int     aH, aD, pH, pD;
    int     aP[N_L];
    int     pP[N_L];
    bit     m_pnd;
    bit     m_applied;
    frame_t m_f;
    frame_t e_fr;
    bit     e_pnd, e_run;

    function automatic void apply_pending();
        aH = (pH < 2) ? 2 : pH;
        aD = (pD >= aH) ? aH - 1 : pD;
        for (int k = 0; k < N_L; k++) aP[k] = (pP[k] >= 2*aH) ? 2*aH - 1 : pP[k];
    endfunction

    function automatic void build_period();
        frame_t f;
        for (int t = 0; t < 2*aH; t++) begin
            f.mod  = (t >= aD) && (t < aH);
            f.modn = (t >= aH + aD);
            f.stb  = (t == 0);
            for (int k = 0; k < N_L; k++) f.clkl[k] = (((t - aP[k] + 2*aH) % (2*aH)) < aH);
            fq.push_back(f);
        end
    endfunction

    always @(posedge clk) begin
        if (!RESET_N) begin
            fq.delete();
            m_mode = 0;
            pH = DEF_HALF;
            pD = DEF_DEAD;
            for (int k = 0; k < N_L; k++) pP[k] = 0;
            apply_pending();
            m_pnd = 1'b0;
            e_fr = '0;
        end else begin
            m_applied = 1'b0;
            if (m_mode == 0) begin
                e_fr = '0;
                if (ENABLE) begin
                    if (m_pnd) begin apply_pending(); m_applied = 1'b1; end
                    fq.delete();
                    build_period();
                    m_mode = 1;
                end
            end else begin
                m_f = fq.pop_front();
                if (m_mode == 2) m_f.clkl = m_f.clkl & e_fr.clkl;
                e_fr = m_f;
                if (fq.size() == 0) begin
                    if (m_pnd) begin apply_pending(); m_applied = 1'b1; end
                    if (ENABLE) build_period();
                end
                m_mode = ENABLE ? 1 : ((fq.size() == 0) ? 0 : 2);
            end
            if (CFG_LOAD) begin
                pH = int'(CFG_HALF);
                pD = int'(CFG_DEAD);
                for (int k = 0; k < N_L; k++) pP[k] = int'(CFG_PHASE[k*CW +: CW]);
            end
            m_pnd = CFG_LOAD | (m_pnd & ~m_applied);
        end
        e_pnd = m_pnd;
        e_run = (m_mode != 0);
    end

    logic [N_L+4:0] act_v, exp_v;
    always @(negedge clk) begin
        if (chk_en) begin
            act_v = {CLK_MOD, CLK_MODN, PERIOD_STB, CLKL_MOD, CFG_PENDING, RUNNING};
            exp_v = {e_fr.mod, e_fr.modn, e_fr.stb, e_fr.clkl, e_pnd, e_run};
            checks++;
            if (act_v !== exp_v) begin
                errs++;
                if (prints < 30) begin
                    prints++;
                    $display("FAIL cycle @%0t {mod,modn,stb,clkl,pnd,run}: got %b expected %b", $time, act_v, exp_v);
                end
            end
            checks++;
            if (CLK_MOD && CLK_MODN) begin
                errs++;
                $display("FAIL overlap @%0t: MOD=%b MODN=%b expected never both 1", $time, CLK_MOD, CLK_MODN);
            end
        end
    end

    int per, nm, nn, fm, fn;
    logic [31:0] m0, m1;

    task automatic set_cfg(input int h, input int d, input int p0, input int p1);
        CFG_HALF  = DIV_W'(h);
        CFG_DEAD  = DEAD_W'(d);
        CFG_PHASE = {CW'(p1), CW'(p0)};
    endtask

    task automatic load_cfg(input int h, input int d, input int p0, input int p1);
        set_cfg(h, d, p0, p1);
        CFG_LOAD = 1'b1;
        @(negedge clk);
        CFG_LOAD = 1'b0;
    endtask

    // Measures one period from a PERIOD_STB frame to the next; frame index i is DUT cnt=i.
    task automatic measure(input int load_idx);
        int guard;
        guard = 0;
        per = 0; nm = 0; nn = 0; fm = -1; fn = -1; m0 = '0; m1 = '0;
        while (!PERIOD_STB && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!PERIOD_STB) begin
            checks++;
            errs++;
            $display("FAIL stb_wait: no PERIOD_STB within %0d cycles", guard);
            per = -1;
            return;
        end
        do begin
            if (CLK_MOD) begin nm++; if (fm < 0) fm = per; end
            if (CLK_MODN) begin nn++; if (fn < 0) fn = per; end
            if (per < 32) begin m0[per] = CLKL_MOD[0]; m1[per] = CLKL_MOD[1]; end
            if (per == load_idx) CFG_LOAD = 1'b1;
            @(negedge clk);
            CFG_LOAD = 1'b0;
            per++;
        end while (!PERIOD_STB && per < 1000);
    endtask

    int n, nmodn, lastmodn, guard;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_outputs", int'({CLK_MOD, CLK_MODN, CLKL_MOD, PERIOD_STB, CFG_PENDING, RUNNING}), 0);

        // Default config H=50 D=4
        RESET_N = 1'b1;
        ENABLE  = 1'b1;
        measure(-1);
        chk("t1_period", per, 100);
        chk("t1_mod_high", nm, 46);
        chk("t1_mod_first", fm, 4);
        chk("t1_modn_high", nn, 46);
        chk("t1_modn_first", fn, 54);
        measure(-1);
        chk("t1_period2", per, 100);

        // Retune H=10 D=2, then H=4 D=1 loaded mid-period at cnt=7
        load_cfg(10, 2, 0, 0);
        measure(-1);
        chk("t2_old_period", per, 20);
        chk("t2_old_mod_high", nm, 8);
        set_cfg(4, 1, 0, 0);
        measure(6);
        chk("t2_period_completes", per, 20);
        measure(-1);
        chk("t2_new_period", per, 8);
        chk("t2_mod_high", nm, 3);
        chk("t2_mod_first", fm, 1);
        chk("t2_modn_high", nn, 3);
        chk("t2_modn_first", fn, 5);

        // Clamping: H=5 D=9 phase 3/12
        load_cfg(5, 9, 3, 12);
        chk("t3_pending", int'(CFG_PENDING), 1);
        measure(-1);
        chk("t3_period", per, 10);
        chk("t3_mod_pulse", nm, 1);
        chk("t3_mod_first", fm, 4);
        chk("t3_modn_first", fn, 9);
        chk("t3_clkl0", int'(m0 & 32'h3FF), 'h0F8);
        chk("t3_clkl1", int'(m1 & 32'h3FF), 'h20F);

        // H<2 clamps to 2, D=0 is gapless
        load_cfg(1, 0, 0, 7);
        measure(-1);
        chk("t3b_period", per, 4);
        chk("t3b_mod_high", nm, 2);
        chk("t3b_modn_first", fn, 2);
        chk("t3b_clkl0", int'(m0 & 32'hF), 'h3);
        chk("t3b_clkl1", int'(m1 & 32'hF), 'h9);

        // ENABLE low at cnt=3 of P=20
        load_cfg(10, 2, 3, 12);
        measure(-1);
        chk("t4_period", per, 20);
        @(negedge clk);
        @(negedge clk);
        ENABLE = 1'b0;
        n = 0; nmodn = 0;
        while (RUNNING && n < 100) begin
            @(negedge clk);
            n++;
            if (CLK_MODN) nmodn++;
        end
        lastmodn = int'(CLK_MODN);
        chk("t4_cycles_to_idle", n, 17);
        chk("t4_modn_full_pulse", nmodn, 8);
        chk("t4_modn_last_frame", lastmodn, 1);
        @(negedge clk);
        chk("t4_idle_outputs", int'({CLK_MOD, CLK_MODN, CLKL_MOD, PERIOD_STB, RUNNING}), 0);

        // Enable with simultaneous load, then reset while MOD is high
        ENABLE = 1'b1;
        load_cfg(7, 1, 0, 0);
        chk("t5_pending_after_start", int'({CFG_PENDING, RUNNING}), 3);
        guard = 0;
        while (!CLK_MOD && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("t5_mod_seen", int'(CLK_MOD), 1);
        RESET_N = 1'b0;
        @(negedge clk);
        chk("t5_reset_outputs", int'({CLK_MOD, CLK_MODN, CLKL_MOD, PERIOD_STB, CFG_PENDING, RUNNING}), 0);
        RESET_N = 1'b1;
        measure(-1);
        chk("t5_default_period", per, 100);
        chk("t5_default_mod_high", nm, 46);

        // Random reloads, enable toggles and occasional reset under the per-cycle model
        for (int i = 0; i < 20000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 40) begin
                set_cfg(int'($urandom_range(0, 24)), int'($urandom_range(0, 30)),
                        int'($urandom_range(0, 60)), int'($urandom_range(0, 60)));
                CFG_LOAD = 1'b1;
            end else begin
                CFG_LOAD = 1'b0;
            end
            if (r >= 990) ENABLE = ~ENABLE;
            RESET_N = (r == 500) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        CFG_LOAD = 1'b0;
        RESET_N  = 1'b1;
        ENABLE   = 1'b1;
        repeat (100) @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
